video_timing_driver: RTL
========================

# video_timing_driver

Generates the raster timing for the 1280x720 display path and drives the panel/encoder. It is the producing end of the pixel-position interface: it issues `pixel_xpos`/`pixel_ypos` ahead of the active region to the pixel pipeline (ROM fetch, Sobel, erosion, expansion), takes the returned `pixel_data`, and presents `video_rgb` aligned with `video_de`, `video_hs` and `video_vs`.

## Interface
- `H_SYNC`, 11'd40, hsync width in pixel clocks
- `H_BACK`, 11'd220, horizontal back porch
- `H_DISP`, 11'd1280, active pixels per line
- `H_FRONT`, 11'd110, horizontal front porch
- `V_SYNC`, 11'd5, vsync width in lines
- `V_BACK`, 11'd20, vertical back porch
- `V_DISP`, 11'd720, active lines
- `V_FRONT`, 11'd5, vertical front porch
- `PIX_LAT`, 1, cycles from position request to `pixel_data` valid; legal 1..4
- `SYNC_POL`, 1'b1, active level of `video_hs`/`video_vs`

- `pixel_clk` in 1 pixel clock; all logic on rising edge
- `sys_rst_n` in 1 reset, synchronous, active-low
- `pixel_data` in 24 pixel returned by pipeline, RGB888
- `pixel_xpos` out 11 requested column, 0..H_DISP-1
- `pixel_ypos` out 11 requested row, 0..V_DISP-1
- `data_req` out 1 high while `pixel_xpos`/`pixel_ypos` name a valid pixel
- `video_hs` out 1 horizontal sync
- `video_vs` out 1 vertical sync
- `video_de` out 1 active-video enable
- `video_rgb` out 24 pixel to display
- `frame_start` out 1 one-cycle pulse at position (0,0) of each frame

## Operation
- Internal counters `h_cnt` 0..H_TOTAL-1 (H_TOTAL = sum of H params = 1650), `v_cnt` 0..V_TOTAL-1 (V_TOTAL = 750). `h_cnt` wraps H_TOTAL-1 -> 0 and increments `v_cnt`; `v_cnt` wraps V_TOTAL-1 -> 0 simultaneously with `h_cnt` wrap.
- HS_ST = H_SYNC+H_BACK (260), VS_ST = V_SYNC+V_BACK (25).
- `video_hs` = SYNC_POL when `h_cnt` < H_SYNC, else ~SYNC_POL. `video_vs` same on `v_cnt` < V_SYNC (whole lines, switching at `h_cnt`=0).
- `video_de` = 1 when HS_ST <= `h_cnt` < HS_ST+H_DISP and VS_ST <= `v_cnt` < VS_ST+V_DISP.
- `data_req` = 1 when HS_ST-PIX_LAT <= `h_cnt` < HS_ST+H_DISP-PIX_LAT and `v_cnt` in the active range. While high: `pixel_xpos` = `h_cnt`-(HS_ST-PIX_LAT), `pixel_ypos` = `v_cnt`-VS_ST. While low both are 0.
- `video_rgb` = `pixel_data` when `video_de`, else 24'h000000 (combinational gate on registered `video_de`).
- `frame_start` = 1 only at `h_cnt`=0, `v_cnt`=0.
- Arithmetic in 11 bits unsigned; no position exceeds 1279/719, no counter exceeds 1649/749.

## Timing
- All outputs except `video_rgb` are registered; `video_rgb` depends combinationally on `pixel_data` and registered `video_de` only.
- Reset: any edge with `sys_rst_n`=0 loads counters to (0,0) and outputs to: `video_hs`=`video_vs`=~SYNC_POL, `video_de`=0, `data_req`=0, positions 0, `frame_start`=0; `video_rgb`=0. Applies mid-frame; no partial line is completed.
- First edge with `sys_rst_n`=1: outputs reflect position (0,0) (`frame_start`=1, syncs active); each later edge advances one position.
- Request-to-display latency: request for (x,y) issued at edge n; `video_de` high for that pixel at edge n+PIX_LAT. Pipeline must return `pixel_data` exactly PIX_LAT cycles after request; no backpressure.
- `data_req` run per line: exactly H_DISP consecutive cycles; `video_de` run: H_DISP cycles starting PIX_LAT later.
- Frame period: H_TOTAL*V_TOTAL = 1,237,500 cycles; line period 1650.

## Test plan
- Reset release -> next edge `frame_start`=1, `video_hs`=`video_vs`=1, `video_de`=0; `frame_start` recurs exactly 1,237,500 cycles later.
- One line at `v_cnt`=25: `video_hs` high 40 cycles from `h_cnt`=0; `data_req` high `h_cnt` 259..1538 with `pixel_xpos` 0..1279; `video_de` high 260..1539.
- Pipeline model returning {xpos,ypos} after PIX_LAT=1 and PIX_LAT=3 -> `video_rgb` at each DE cycle equals its own column/row; zero outside DE.
- Vertical: `video_vs` high for `v_cnt` 0..4 (8250 cycles); `data_req`/`video_de` only on lines 25..744; `pixel_ypos` 719 on last active line, 0 on line 745.
- Reset asserted for 3 cycles at `h_cnt`=700, `v_cnt`=300 -> all outputs at reset values during reset; restart at (0,0) with `frame_start`=1.
- Wrap: at `h_cnt`=1649, `v_cnt`=749 next edge gives (0,0), `frame_start`=1, no extra DE cycle, `data_req` low.

Source files
------------

// File: rtl/video_timing_driver.sv
// Raster timing generator: runs the h/v counters, issues pixel positions PIX_LAT
// cycles ahead of active video and gates the returned pixel onto video_rgb.
module video_timing_driver #(
  parameter logic [10:0] H_SYNC   = 11'd40,
  parameter logic [10:0] H_BACK   = 11'd220,
  parameter logic [10:0] H_DISP   = 11'd1280,
  parameter logic [10:0] H_FRONT  = 11'd110,
  parameter logic [10:0] V_SYNC   = 11'd5,
  parameter logic [10:0] V_BACK   = 11'd20,
  parameter logic [10:0] V_DISP   = 11'd720,
  parameter logic [10:0] V_FRONT  = 11'd5,
  parameter int          PIX_LAT  = 1,
  parameter logic        SYNC_POL = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        sys_rst_n,
  input  logic [23:0] pixel_data,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        data_req,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb,
  output logic        frame_start
);

  localparam logic [10:0] H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam logic [10:0] V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam logic [10:0] HS_ST   = H_SYNC + H_BACK;
  localparam logic [10:0] HS_END  = HS_ST + H_DISP;
  localparam logic [10:0] VS_ST   = V_SYNC + V_BACK;
  localparam logic [10:0] VS_END  = VS_ST + V_DISP;
  localparam logic [10:0] LAT     = 11'(PIX_LAT);
  localparam logic [10:0] REQ_ST  = HS_ST - LAT;
  localparam logic [10:0] REQ_END = HS_END - LAT;

  logic        running;
  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [10:0] h_nxt;
  logic [10:0] v_nxt;
  logic        v_act_nxt;
  logic        req_nxt;

  // The counters hold at (0,0) on the first edge after reset so that edge
  // presents position (0,0); every later edge advances one position.
  always_comb begin
    h_nxt = h_cnt;
    v_nxt = v_cnt;
    if (running) begin
      if (h_cnt == H_TOTAL - 11'd1) begin
        h_nxt = '0;
        v_nxt = (v_cnt == V_TOTAL - 11'd1) ? '0 : v_cnt + 11'd1;
      end else begin
        h_nxt = h_cnt + 11'd1;
      end
    end
    v_act_nxt = (v_nxt >= VS_ST) && (v_nxt < VS_END);
    req_nxt   = v_act_nxt && (h_nxt >= REQ_ST) && (h_nxt < REQ_END);
  end

  always_ff @(posedge pixel_clk) begin
    if (!sys_rst_n) begin
      running     <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      video_hs    <= ~SYNC_POL;
      video_vs    <= ~SYNC_POL;
      video_de    <= 1'b0;
      data_req    <= 1'b0;
      pixel_xpos  <= '0;
      pixel_ypos  <= '0;
      frame_start <= 1'b0;
    end else begin
      running     <= 1'b1;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      video_hs    <= (h_nxt < H_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_vs    <= (v_nxt < V_SYNC) ? SYNC_POL : ~SYNC_POL;
      video_de    <= v_act_nxt && (h_nxt >= HS_ST) && (h_nxt < HS_END);
      data_req    <= req_nxt;
      pixel_xpos  <= req_nxt ? h_nxt - REQ_ST : '0;
      pixel_ypos  <= req_nxt ? v_nxt - VS_ST : '0;
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end
  end

  assign video_rgb = video_de ? pixel_data : '0;

endmodule
